// File: rtl/reg_file_arb_pkg.sv
// Shared types and constants for the reg_file arbiter.
package reg_file_arb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } arb_state_t;

    // Requester IDs, also used as bit positions in the one-hot grant vector
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/reg_file_rr2.sv
// Combinational two-way round-robin pick; prio names the requester that
// wins when both ask. The pointer itself is kept by the parent.
module reg_file_rr2
    import reg_file_arb_pkg::*;
(
    input  logic       a_req,
    input  logic       b_req,
    input  logic       prio,
    output logic [1:0] gnt
);

    // One-hot grant: a lone requester wins, otherwise the prio holder wins
    always_comb begin
        gnt = '0;
        if (a_req && (!b_req || prio == REQ_A)) begin
            gnt[REQ_A] = 1'b1;
        end else if (b_req) begin
            gnt[REQ_B] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter/sequencer in front of reg_file. Grants one
// single-beat request per cycle, drives registered write/read ports and
// returns read data two cycles after the grant.
// Optional macro REG_FILE_ARB_CLEAR_EN: zero-fill all 2^N entries after
// reset before accepting traffic (busy high meanwhile).
module reg_file_arbiter
    import reg_file_arb_pkg::*;
#(
    parameter int N    = 7,
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_req,
    input  logic            b_req,
    input  logic            a_we,
    input  logic            b_we,
    input  logic [N-1:0]    a_addr,
    input  logic [N-1:0]    b_addr,
    input  logic [BITS-1:0] a_wdata,
    input  logic [BITS-1:0] b_wdata,
    output logic            a_gnt,
    output logic            b_gnt,
    output logic            a_rvalid,
    output logic            b_rvalid,
    output logic [BITS-1:0] a_rdata,
    output logic [BITS-1:0] b_rdata,
    output logic [N-1:0]    rf_address_w,
    output logic [BITS-1:0] rf_data_w,
    output logic            rf_WE,
    output logic [N-1:0]    rf_address_r,
    input  logic [BITS-1:0] rf_data_r,
    output logic            busy
);

`ifdef REG_FILE_ARB_CLEAR_EN
    localparam arb_state_t RESET_STATE = CLEAR;
    logic [N-1:0] clr_addr;
`else
    localparam arb_state_t RESET_STATE = RUN;
`endif

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic            run_en;
    logic            prio;
    logic [1:0]      gnt;
    logic            sel_b;
    logic            any_gnt;
    logic            g_we;
    logic [N-1:0]    g_addr;
    logic [BITS-1:0] g_wdata;
    logic            rd_pend;
    logic            rd_tag;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR once the last entry has been written
    always_comb begin
        state_nxt = state;
`ifdef REG_FILE_ARB_CLEAR_EN
        if (state == CLEAR && clr_addr == '1) begin
            state_nxt = RUN;
        end
`else
        state_nxt = RUN;
`endif
    end

    // FSM outputs; grants are also held off while reset is asserted
    always_comb begin
        run_en = (state == RUN) && !reset;
`ifdef REG_FILE_ARB_CLEAR_EN
        busy   = (state == CLEAR);
`else
        busy   = 1'b0;
`endif
    end

`ifdef REG_FILE_ARB_CLEAR_EN
    // Clear address counter, one entry per CLEAR cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= clr_addr + {{(N-1){1'b0}}, 1'b1};
        end
    end
`endif

    reg_file_rr2 u_rr2 (
        .a_req (a_req && run_en),
        .b_req (b_req && run_en),
        .prio  (prio),
        .gnt   (gnt)
    );

    assign a_gnt   = gnt[REQ_A];
    assign b_gnt   = gnt[REQ_B];
    assign sel_b   = gnt[REQ_B];
    assign any_gnt = |gnt;
    assign g_we    = sel_b ? b_we    : a_we;
    assign g_addr  = sel_b ? b_addr  : a_addr;
    assign g_wdata = sel_b ? b_wdata : a_wdata;

    // Priority pointer flips to the other requester after every grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= REQ_A;
        end else if (any_gnt) begin
            prio <= sel_b ? REQ_A : REQ_B;
        end
    end

    // Registered write port: clear writes, granted writes, else WE drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_WE        <= 1'b0;
            rf_address_w <= '0;
            rf_data_w    <= '0;
        end else begin
`ifdef REG_FILE_ARB_CLEAR_EN
            if (state == CLEAR) begin
                rf_WE        <= 1'b1;
                rf_address_w <= clr_addr;
                rf_data_w    <= '0;
            end else
`endif
            if (any_gnt && g_we) begin
                rf_WE        <= 1'b1;
                rf_address_w <= g_addr;
                rf_data_w    <= g_wdata;
            end else begin
                rf_WE        <= 1'b0;
            end
        end
    end

    // Registered read address plus one-deep requester tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_address_r <= '0;
            rd_pend      <= 1'b0;
            rd_tag       <= REQ_A;
        end else if (any_gnt && !g_we) begin
            rf_address_r <= g_addr;
            rd_pend      <= 1'b1;
            rd_tag       <= sel_b ? REQ_B : REQ_A;
        end else begin
            rd_pend      <= 1'b0;
        end
    end

    // Read return: capture file data for the tagged requester, pulse rvalid
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= rd_pend && (rd_tag == REQ_A);
            b_rvalid <= rd_pend && (rd_tag == REQ_B);
            if (rd_pend && rd_tag == REQ_A) begin
                a_rdata <= rf_data_r;
            end
            if (rd_pend && rd_tag == REQ_B) begin
                b_rdata <= rf_data_r;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Directed self-checking bench for reg_file_arbiter with a behavioural
// reg_file attached to its rf_* ports.
module tb_reg_file_arbiter;

    localparam int N    = 7;
    localparam int BITS = 4;
`ifdef REG_FILE_ARB_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            a_req, b_req, a_we, b_we;
    logic [N-1:0]    a_addr, b_addr;
    logic [BITS-1:0] a_wdata, b_wdata;
    logic            a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [BITS-1:0] a_rdata, b_rdata;
    logic [N-1:0]    rf_address_w, rf_address_r;
    logic [BITS-1:0] rf_data_w, rf_data_r;
    logic            rf_WE, busy;

    logic [BITS-1:0] mem [0:(1<<N)-1];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_WE) mem[rf_address_w] <= rf_data_w;
    end
    assign rf_data_r = mem[rf_address_r];

    reg_file_arbiter #(.N(N), .BITS(BITS)) dut (
        .clk          (clk),
        .reset        (reset),
        .a_req        (a_req),
        .b_req        (b_req),
        .a_we         (a_we),
        .b_we         (b_we),
        .a_addr       (a_addr),
        .b_addr       (b_addr),
        .a_wdata      (a_wdata),
        .b_wdata      (b_wdata),
        .a_gnt        (a_gnt),
        .b_gnt        (b_gnt),
        .a_rvalid     (a_rvalid),
        .b_rvalid     (b_rvalid),
        .a_rdata      (a_rdata),
        .b_rdata      (b_rdata),
        .rf_address_w (rf_address_w),
        .rf_data_w    (rf_data_w),
        .rf_WE        (rf_WE),
        .rf_address_r (rf_address_r),
        .rf_data_r    (rf_data_r),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " a_gnt"},        32'(a_gnt),        0);
        chk({tag, " b_gnt"},        32'(b_gnt),        0);
        chk({tag, " a_rvalid"},     32'(a_rvalid),     0);
        chk({tag, " b_rvalid"},     32'(b_rvalid),     0);
        chk({tag, " a_rdata"},      32'(a_rdata),      0);
        chk({tag, " b_rdata"},      32'(b_rdata),      0);
        chk({tag, " rf_WE"},        32'(rf_WE),        0);
        chk({tag, " rf_address_w"}, 32'(rf_address_w), 0);
        chk({tag, " rf_data_w"},    32'(rf_data_w),    0);
        chk({tag, " rf_address_r"}, 32'(rf_address_r), 0);
        chk({tag, " busy"},         32'(busy),         32'(BUSY_RST));
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
        a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;

        // Reset: requests present but nothing is granted
        step();
        a_req = 1'b1; b_req = 1'b1;
        mid();
        chk_reset_vals("rst");
        step();
        reset = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;

`ifdef REG_FILE_ARB_CLEAR_EN
        // Clear sequence: 128 busy cycles, writes of 0 to 0..127, no grant
        b_req = 1'b1; b_we = 1'b0; b_addr = '0;
        for (int i = 0; i <= 128; i++) begin
            mid();
            chk("clr busy",  32'(busy),  32'(i < 128));
            chk("clr b_gnt", 32'(b_gnt), 32'(i == 128));
            chk("clr rf_WE", 32'(rf_WE), 32'(i > 0));
            if (i > 0) begin
                chk("clr rf_address_w", 32'(rf_address_w), 32'(i - 1));
                chk("clr rf_data_w",    32'(rf_data_w),    0);
            end
            step();
        end
        b_req = 1'b0;
        step(); step(); step();
`endif

        // Same-address writes in one cycle: A first (prio A), then B
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'd3; a_wdata = 4'h5;
        b_req = 1'b1; b_we = 1'b1; b_addr = 7'd3; b_wdata = 4'h9;
        mid();
        chk("wr2 a_gnt", 32'(a_gnt), 1);
        chk("wr2 b_gnt", 32'(b_gnt), 0);
        step();
        a_req = 1'b0;
        mid();
        chk("wr2 b_gnt next", 32'(b_gnt), 1);
        chk("wr2 a_gnt next", 32'(a_gnt), 0);
        chk("wr2 rf_WE a",    32'(rf_WE), 1);
        chk("wr2 rf_address_w", 32'(rf_address_w), 3);
        chk("wr2 rf_data_w a",  32'(rf_data_w), 5);
        step();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'd3;
        mid();
        chk("rd3 a_gnt",       32'(a_gnt), 1);
        chk("wr2 rf_WE b",     32'(rf_WE), 1);
        chk("wr2 rf_data_w b", 32'(rf_data_w), 9);
        step();
        a_req = 1'b0;
        mid();
        chk("rd3 rf_WE idle",     32'(rf_WE), 0);
        chk("rd3 rf_address_r",   32'(rf_address_r), 3);
        chk("rd3 a_rvalid early", 32'(a_rvalid), 0);
        step();
        mid();
        chk("rd3 a_rvalid", 32'(a_rvalid), 1);
        chk("rd3 a_rdata",  32'(a_rdata), 9);
        chk("rd3 b_rvalid", 32'(b_rvalid), 0);
        step();
        mid();
        chk("rd3 a_rvalid pulse", 32'(a_rvalid), 0);
        chk("rd3 a_rdata hold",   32'(a_rdata), 9);

        // Write-then-read hazard: B sees A's new data
        step();
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'd10; a_wdata = 4'hC;
        mid();
        chk("haz a_gnt", 32'(a_gnt), 1);
        step();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 7'd10;
        mid();
        chk("haz b_gnt", 32'(b_gnt), 1);
        step();
        b_req = 1'b0;
        mid();
        chk("haz b_rvalid early", 32'(b_rvalid), 0);
        step();
        mid();
        chk("haz b_rvalid", 32'(b_rvalid), 1);
        chk("haz b_rdata",  32'(b_rdata), 32'hC);
        chk("haz a_rvalid", 32'(a_rvalid), 0);

        // Contention for 6 cycles: A,B,A,B,A,B with pipelined returns
        step();
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'd3;
        b_req = 1'b1; b_we = 1'b0; b_addr = 7'd10;
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("rr a_gnt",  32'(a_gnt), 32'(i % 2 == 0));
            chk("rr b_gnt",  32'(b_gnt), 32'(i % 2 == 1));
            chk("rr onehot", 32'(a_gnt & b_gnt), 0);
            if (i >= 2) begin
                chk("rr a_rvalid", 32'(a_rvalid), 32'(i % 2 == 0));
                chk("rr b_rvalid", 32'(b_rvalid), 32'(i % 2 == 1));
            end
            step();
        end
        a_req = 1'b0; b_req = 1'b0;
        step(); step();

        // Preload 1..3 then back-to-back reads from A
        for (int i = 1; i <= 3; i++) begin
            a_req = 1'b1; a_we = 1'b1; a_addr = N'(i); a_wdata = BITS'(i);
            mid();
            chk("pre a_gnt", 32'(a_gnt), 1);
            step();
        end
        for (int i = 1; i <= 3; i++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = N'(i);
            mid();
            chk("b2b a_gnt", 32'(a_gnt), 1);
            chk("b2b a_rvalid", 32'(a_rvalid), 32'(i == 3));
            if (i == 3) chk("b2b a_rdata 1", 32'(a_rdata), 1);
            step();
        end
        a_req = 1'b0;
        mid();
        chk("b2b a_rvalid 2", 32'(a_rvalid), 1);
        chk("b2b a_rdata 2",  32'(a_rdata), 2);
        step();
        mid();
        chk("b2b a_rvalid 3", 32'(a_rvalid), 1);
        chk("b2b a_rdata 3",  32'(a_rdata), 3);
        step();
        mid();
        chk("b2b a_rvalid end", 32'(a_rvalid), 0);
        chk("b2b a_rdata hold", 32'(a_rdata), 3);

        // Reset right after a read grant: outputs clear at once, no rvalid
        step();
        a_req = 1'b1; a_we = 1'b0; a_addr = 7'd2;
        mid();
        chk("mrst a_gnt", 32'(a_gnt), 1);
        step();
        a_req = 1'b0;
        reset = 1'b1;
        #1;
        chk_reset_vals("mrst");
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("mrst a_rvalid", 32'(a_rvalid), 0);
            chk("mrst b_rvalid", 32'(b_rvalid), 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
